// File: rtl/dmem_port.sv
// CPU data-memory port: a 2^AW x 16 RAM with a write-only stream register that
// feeds a ready/valid output FIFO, plus a read-only status register.
module dmem_port #(
  parameter int AW = 7,
  parameter int FD = 4
) (
  input  logic        CK,
  input  logic        RST,
  input  logic [15:0] DA,
  inout  wire  [15:0] DD,
  input  logic        RW,
  output logic [15:0] OUTD,
  output logic        OUTV,
  input  logic        OUTR,
  output logic        OVF
);

  localparam int PW = $clog2(FD) + 1;
  localparam logic [AW-1:0] STREAM_A = {AW{1'b1}};
  localparam logic [AW-1:0] STATUS_A = {{(AW-1){1'b1}}, 1'b0};
  localparam logic [PW-1:0] FULL_PAT = {1'b1, {(PW-1){1'b0}}};

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} fifo_state_e;

  logic [15:0]   mem_q  [2**AW];
  logic [15:0]   fifo_q [FD];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   rd_word_q, rd_word_d;

  logic [AW-1:0] addr;
  logic [PW-1:0] cnt;
  fifo_state_e   fstate;
  logic          push_req, push, pop, mem_we;

  function automatic logic [15:0] status_word(input logic ovf, input logic [PW-1:0] c);
    logic [15:0] w;
    w = 16'(c);
    return {ovf, 11'b0, w[3:0]};
  endfunction

  if (AW < 16) begin : g_unused
    logic unused_da;
    assign unused_da = ^DA[15:AW];
  end

  always_comb begin
    addr      = DA[AW-1:0];
    cnt       = wr_ptr_q - rd_ptr_q;
    fstate    = PARTIAL;
    if (wr_ptr_q == rd_ptr_q)
      fstate = EMPTY;
    else if ((wr_ptr_q ^ rd_ptr_q) == FULL_PAT)
      fstate = FULL;

    pop       = (fstate != EMPTY) && OUTR;
    push_req  = !RW && (addr == STREAM_A);
    // A full FIFO still accepts a push when a pop frees the slot in the same edge.
    push      = push_req && ((fstate != FULL) || pop);
    mem_we    = !RW && (addr != STREAM_A) && (addr != STATUS_A);

    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    ovf_d     = ovf_q | (push_req && !push);

    rd_word_d = rd_word_q;
    if (RW) begin
      if (addr == STREAM_A)
        rd_word_d = 16'h0000;
      else if (addr == STATUS_A)
        rd_word_d = status_word(ovf_q, cnt);
      else
        rd_word_d = mem_q[addr];
    end
  end

  always_ff @(posedge CK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ovf_q     <= 1'b0;
      rd_word_q <= 16'h0000;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ovf_q     <= ovf_d;
      rd_word_q <= rd_word_d;
    end
  end

  // Storage arrays carry no reset; occupancy is governed by the pointers alone.
  always_ff @(posedge CK) begin
    if (mem_we)
      mem_q[addr] <= DD;
    if (push)
      fifo_q[wr_ptr_q[PW-2:0]] <= DD;
  end

  assign OUTD = fifo_q[rd_ptr_q[PW-2:0]];
  assign OUTV = (fstate != EMPTY);
  assign OVF  = ovf_q;
  assign DD   = RW ? rd_word_q : {16{1'bz}};

endmodule

// File: tb/tb_dmem_port.sv
// Randomized bench for dmem_port against a queue/array reference model.
module tb_dmem_port;

  localparam int AW = 7;
  localparam int FD = 4;
  localparam logic [AW-1:0] STREAM = 7'h7F;
  localparam logic [AW-1:0] STATUS = 7'h7E;

  logic        CK;
  logic        RST;
  logic [15:0] DA;
  logic        RW;
  logic [15:0] OUTD;
  logic        OUTV;
  logic        OUTR;
  logic        OVF;
  wire  [15:0] DD;
  logic [15:0] dd_drv;
  logic        dd_oe;

  assign DD = dd_oe ? dd_drv : {16{1'bz}};

  dmem_port #(.AW(AW), .FD(FD)) dut (
    .CK(CK), .RST(RST), .DA(DA), .DD(DD), .RW(RW),
    .OUTD(OUTD), .OUTV(OUTV), .OUTR(OUTR), .OVF(OVF)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] ram_m [2**AW];
  logic [15:0] q_m [$];
  logic        ovf_m;
  logic [15:0] rd_m;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] bit16(input logic b);
    return b ? 16'd1 : 16'd0;
  endfunction

  // One bus cycle: drive after negedge, check before posedge, advance model at posedge.
  task automatic step(input logic rw, input logic [15:0] da, input logic [15:0] wd, input logic outr);
    logic [AW-1:0] a;
    logic          pop;
    logic          full;
    RW = rw; DA = da; OUTR = outr;
    dd_oe = !rw; dd_drv = wd;
    #1;
    check_val("outv", bit16(OUTV), bit16(q_m.size() != 0));
    check_val("ovf", bit16(OVF), bit16(ovf_m));
    if (q_m.size() != 0) check_val("outd", OUTD, q_m[0]);
    if (rw) check_val("dd_read", DD, rd_m);
    else    check_val("dd_undriven", DD, wd);

    a    = da[AW-1:0];
    pop  = (q_m.size() != 0) && outr;
    full = (q_m.size() == FD);
    if (rw) begin
      if (a == STREAM)      rd_m = 16'h0000;
      else if (a == STATUS) rd_m = {ovf_m, 11'b0, 4'(q_m.size())};
      else                  rd_m = ram_m[a];
      if (pop) void'(q_m.pop_front());
    end else begin
      if (pop) void'(q_m.pop_front());
      if (a == STREAM) begin
        if (!full || pop) q_m.push_back(wd);
        else ovf_m = 1'b1;
      end else if (a != STATUS) begin
        ram_m[a] = wd;
      end
    end
    @(posedge CK);
    @(negedge CK);
  endtask

  task automatic async_reset();
    RW = 1'b1; dd_oe = 1'b0; OUTR = 1'b0; DA = 16'h0000;
    #2 RST = 1'b0;
    #1;
    q_m.delete(); ovf_m = 1'b0; rd_m = 16'h0000;
    check_val("rst_outv", bit16(OUTV), bit16(q_m.size() != 0));
    check_val("rst_ovf", bit16(OVF), bit16(ovf_m));
    check_val("rst_dd", DD, rd_m);
    @(negedge CK);
    RST = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] da;
    int          r;
    RST = 1'b0; RW = 1'b1; DA = 16'h0000; OUTR = 1'b0; dd_oe = 1'b0; dd_drv = 16'h0000;
    ovf_m = 1'b0; rd_m = 16'h0000;
    @(negedge CK); @(negedge CK);
    check_val("reset_outv", bit16(OUTV), 16'd0);
    check_val("reset_ovf", bit16(OVF), 16'd0);
    check_val("reset_dd", DD, 16'h0000);
    RST = 1'b1;

    // RAM write then back-to-back reads
    step(1'b0, 16'd0, 16'h0004, 1'b0);
    step(1'b0, 16'd1, 16'h0002, 1'b0);
    step(1'b1, 16'd0, 16'h0000, 1'b0);
    step(1'b1, 16'd1, 16'h0000, 1'b0);
    step(1'b1, 16'd0, 16'h0000, 1'b0);

    // RW=0 cycles: bus must carry only the bench's value
    for (int i = 0; i < 3; i++) step(1'b0, 16'd10, 16'h0000, 1'b0);
    step(1'b0, 16'd5, 16'hBEEF, 1'b0);
    step(1'b1, 16'd5, 16'h0000, 1'b0);
    step(1'b1, {9'd0, STATUS}, 16'h0000, 1'b0);

    // Fill, then push into full FIFO while popping: accepted, no overflow
    step(1'b0, {9'd0, STREAM}, 16'h0011, 1'b0);
    step(1'b0, {9'd0, STREAM}, 16'h0022, 1'b0);
    step(1'b0, {9'd0, STREAM}, 16'h0033, 1'b0);
    step(1'b0, {9'd0, STREAM}, 16'h0044, 1'b0);
    step(1'b0, {9'd0, STREAM}, 16'h0066, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, {9'd0, STATUS}, 16'h0000, 1'b1);

    // Overflow: fifth push dropped, status reads 0x8004, drain in order
    step(1'b0, {9'd0, STREAM}, 16'h0011, 1'b0);
    step(1'b0, {9'd0, STREAM}, 16'h0022, 1'b0);
    step(1'b0, {9'd0, STREAM}, 16'h0033, 1'b0);
    step(1'b0, {9'd0, STREAM}, 16'h0044, 1'b0);
    step(1'b0, {9'd0, STREAM}, 16'h0055, 1'b0);
    step(1'b1, {9'd0, STATUS}, 16'h0000, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, {9'd0, STATUS}, 16'h0000, 1'b1);
    step(1'b1, {9'd0, STREAM}, 16'h0000, 1'b1);
    step(1'b1, {9'd0, STATUS}, 16'h0000, 1'b1);

    // Async reset with two entries queued and OVF set; RAM survives
    step(1'b0, {9'd0, STREAM}, 16'h0077, 1'b0);
    step(1'b0, {9'd0, STREAM}, 16'h0088, 1'b0);
    async_reset();
    step(1'b1, 16'd0, 16'h0000, 1'b0);
    step(1'b1, {9'd0, STATUS}, 16'h0000, 1'b0);

    for (int a = 0; a < 2**AW - 2; a++) step(1'b0, 16'(a), 16'($urandom), 1'b0);

    for (int i = 0; i < 600; i++) begin
      if (i == 300) async_reset();
      r  = $urandom_range(0, 9);
      da = 16'($urandom);
      if (r < 4)       da[AW-1:0] = STREAM;
      else if (r == 4) da[AW-1:0] = STATUS;
      step(1'($urandom_range(0, 1)), da, 16'($urandom), $urandom_range(0, 2) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
